// File: rtl/recon_bitstream_reader_pkg.sv
// recon_pkg: status codes, AXI constants and FSM encoding shared by the bitstream reader.
package recon_pkg;
   localparam logic [3:0] RECON_ST_OK       = 4'd0;
   localparam logic [3:0] RECON_ST_RRESP    = 4'd1;
   localparam logic [3:0] RECON_ST_ZERO_LEN = 4'd2;
   localparam logic [1:0] RECON_AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] RECON_AXI_CACHE      = 4'b0011;
   localparam int RECON_PAGE_BYTES = 4096;
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_STATUS} recon_state_e;
endpackage

// File: rtl/recon_bitstream_reader_if.sv
// recon_bitstream_reader_if: descriptor, status, AXI4 read and AXI-stream signals of the reader.
interface recon_bitstream_reader_if #(
   parameter int DATA_WIDTH         = 64,
   parameter int ADDR_WIDTH         = 34,
   parameter int ID_WIDTH           = 8,
   parameter int DMA_DESC_LEN_WIDTH = 20,
   parameter int DMA_DESC_TAG_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]         s_axis_read_desc_addr;
   logic [DMA_DESC_LEN_WIDTH-1:0] s_axis_read_desc_len;
   logic [DMA_DESC_TAG_WIDTH-1:0] s_axis_read_desc_tag;
   logic                          s_axis_read_desc_valid;
   logic                          s_axis_read_desc_ready;
   logic [DMA_DESC_TAG_WIDTH-1:0] m_axis_read_desc_status_tag;
   logic [3:0]                    m_axis_read_desc_status_error;
   logic                          m_axis_read_desc_status_valid;
   logic [ID_WIDTH-1:0]           m_axi_arid;
   logic [ADDR_WIDTH-1:0]         m_axi_araddr;
   logic [7:0]                    m_axi_arlen;
   logic [2:0]                    m_axi_arsize;
   logic [1:0]                    m_axi_arburst;
   logic                          m_axi_arlock;
   logic [3:0]                    m_axi_arcache;
   logic [2:0]                    m_axi_arprot;
   logic                          m_axi_arvalid;
   logic                          m_axi_arready;
   logic [ID_WIDTH-1:0]           m_axi_rid;
   logic [DATA_WIDTH-1:0]         m_axi_rdata;
   logic [1:0]                    m_axi_rresp;
   logic                          m_axi_rlast;
   logic                          m_axi_rvalid;
   logic                          m_axi_rready;
   logic [DATA_WIDTH-1:0]         m_axis_tdata;
   logic [DATA_WIDTH/8-1:0]       m_axis_tkeep;
   logic                          m_axis_tvalid;
   logic                          m_axis_tready;
   logic                          m_axis_tlast;
   logic                          m_axis_tuser;
   modport master (
      input  s_axis_read_desc_addr, s_axis_read_desc_len, s_axis_read_desc_tag, s_axis_read_desc_valid,
      output s_axis_read_desc_ready,
      output m_axis_read_desc_status_tag, m_axis_read_desc_status_error, m_axis_read_desc_status_valid,
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
      output m_axi_arcache, m_axi_arprot, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_rready,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      input  m_axis_tready
   );
   modport slave (
      output s_axis_read_desc_addr, s_axis_read_desc_len, s_axis_read_desc_tag, s_axis_read_desc_valid,
      input  s_axis_read_desc_ready,
      input  m_axis_read_desc_status_tag, m_axis_read_desc_status_error, m_axis_read_desc_status_valid,
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
      input  m_axi_arcache, m_axi_arprot, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_rready,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      output m_axis_tready
   );
endinterface

// File: rtl/recon_bitstream_reader_skid_buf.sv
// recon_axis_skid_buf: 2-entry skid buffer with registered stream outputs and full throughput.
module recon_axis_skid_buf #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   in_data_i,
   input  logic [DATA_WIDTH/8-1:0] in_keep_i,
   input  logic                    in_last_i,
   input  logic                    in_user_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   output logic [DATA_WIDTH-1:0]   out_data_o,
   output logic [DATA_WIDTH/8-1:0] out_keep_o,
   output logic                    out_last_o,
   output logic                    out_user_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i
);
   localparam int W = DATA_WIDTH + DATA_WIDTH / 8 + 2;
   logic [W-1:0] in_w, out_q, out_d, skid_q, skid_d;
   logic out_v_q, out_v_d, skid_v_q, skid_v_d, out_take;
   assign in_w       = {in_data_i, in_keep_i, in_last_i, in_user_i};
   assign in_ready_o = !skid_v_q;
   assign out_take   = !out_v_q || out_ready_i;
   assign {out_data_o, out_keep_o, out_last_o, out_user_o} = out_q;
   assign out_valid_o = out_v_q;
   // The skid entry only fills when the output register is stalled.
   always_comb begin
      out_d    = out_q;
      out_v_d  = out_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (out_take) begin
         out_d    = skid_v_q ? skid_q : in_w;
         out_v_d  = skid_v_q || in_valid_i;
         skid_v_d = 1'b0;
      end else if (in_valid_i && !skid_v_q) begin
         skid_d   = in_w;
         skid_v_d = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         out_v_q  <= 1'b0;
         skid_q   <= '0;
         skid_v_q <= 1'b0;
      end else begin
         out_q    <= out_d;
         out_v_q  <= out_v_d;
         skid_q   <= skid_d;
         skid_v_q <= skid_v_d;
      end
   end
endmodule

// File: rtl/recon_bitstream_reader.sv
// recon_bitstream_reader: fetches a descriptor's bitstream over AXI4 read bursts and re-emits it as AXI-stream.
// Define RECON_BITSTREAM_READER_STATS_EN to add descriptor/beat/error counters.
module recon_bitstream_reader
   import recon_pkg::*;
#(
   parameter int DATA_WIDTH         = 64,
   parameter int ADDR_WIDTH         = 34,
   parameter int ID_WIDTH           = 8,
   parameter int DMA_DESC_LEN_WIDTH = 20,
   parameter int DMA_DESC_TAG_WIDTH = 8,
   parameter int MAX_BURST_LEN      = 16,
   parameter int AXI_ID             = 0
) (
   input  logic clk,
   input  logic rst_n,
   recon_bitstream_reader_if.master bus_if
`ifdef RECON_BITSTREAM_READER_STATS_EN
   ,
   output logic [31:0] stat_desc_count,
   output logic [31:0] stat_beat_count,
   output logic [15:0] stat_err_count
`endif
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFFS  = $clog2(BYTES);
   localparam int BR_W  = DMA_DESC_LEN_WIDTH + 1;
   recon_state_e state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DMA_DESC_TAG_WIDTH-1:0] tag_q, tag_d;
   logic [BR_W-1:0] beats_rem_q, beats_rem_d;
   logic [8:0] burst_rem_q, burst_rem_d;
   logic [BYTES-1:0] last_keep_q, last_keep_d;
   logic [3:0] err_q, err_d;
   logic desc_ready_q, desc_ready_d;
   logic desc_fire, ar_fire, r_fire, final_beat, skid_ready, zero_len;
   int page_beats, burst_beats, len_rem;
   logic unused;
   assign desc_fire  = bus_if.s_axis_read_desc_valid && desc_ready_q;
   assign ar_fire    = bus_if.m_axi_arvalid && bus_if.m_axi_arready;
   assign r_fire     = bus_if.m_axi_rvalid && bus_if.m_axi_rready;
   assign final_beat = beats_rem_q == BR_W'(1);
   assign zero_len   = bus_if.s_axis_read_desc_len == '0;
   assign unused     = ^{bus_if.m_axi_rid, bus_if.m_axi_rlast};
   // Burst never crosses a 4 KB page and never exceeds what the descriptor still needs.
   always_comb begin
      page_beats  = (RECON_PAGE_BYTES - int'(addr_q[11:0])) / BYTES;
      burst_beats = MAX_BURST_LEN;
      burst_beats = int'(beats_rem_q) < burst_beats ? int'(beats_rem_q) : burst_beats;
      burst_beats = page_beats < burst_beats ? page_beats : burst_beats;
   end
   assign bus_if.m_axi_arid    = ID_WIDTH'(AXI_ID);
   assign bus_if.m_axi_araddr  = addr_q;
   assign bus_if.m_axi_arlen   = 8'(burst_beats - 1);
   assign bus_if.m_axi_arsize  = 3'(OFFS);
   assign bus_if.m_axi_arburst = RECON_AXI_BURST_INCR;
   assign bus_if.m_axi_arlock  = 1'b0;
   assign bus_if.m_axi_arcache = RECON_AXI_CACHE;
   assign bus_if.m_axi_arprot  = 3'b000;
   assign bus_if.m_axi_arvalid = state_q == ST_ADDR;
   assign bus_if.m_axi_rready  = state_q == ST_DATA && skid_ready;
   assign bus_if.s_axis_read_desc_ready         = desc_ready_q;
   assign bus_if.m_axis_read_desc_status_tag    = tag_q;
   assign bus_if.m_axis_read_desc_status_error  = err_q;
   assign bus_if.m_axis_read_desc_status_valid  = state_q == ST_STATUS;
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      tag_d       = tag_q;
      beats_rem_d = beats_rem_q;
      burst_rem_d = burst_rem_q;
      last_keep_d = last_keep_q;
      err_d       = err_q;
      len_rem     = int'(bus_if.s_axis_read_desc_len) % BYTES;
      case (state_q)
         ST_IDLE: if (desc_fire) begin
            addr_d      = bus_if.s_axis_read_desc_addr & ~ADDR_WIDTH'(BYTES - 1);
            tag_d       = bus_if.s_axis_read_desc_tag;
            beats_rem_d = BR_W'((int'(bus_if.s_axis_read_desc_len) + BYTES - 1) / BYTES);
            for (int i = 0; i < BYTES; i++) last_keep_d[i] = len_rem == 0 || i < len_rem;
            err_d       = zero_len ? RECON_ST_ZERO_LEN : RECON_ST_OK;
            state_d     = zero_len ? ST_STATUS : ST_ADDR;
         end
         ST_ADDR: if (ar_fire) begin
            addr_d      = addr_q + ADDR_WIDTH'(burst_beats * BYTES);
            burst_rem_d = 9'(burst_beats);
            state_d     = ST_DATA;
         end
         // Beat counts, not rlast, decide where each burst and the descriptor end.
         ST_DATA: if (r_fire) begin
            beats_rem_d = beats_rem_q - BR_W'(1);
            burst_rem_d = burst_rem_q - 9'd1;
            err_d       = (bus_if.m_axi_rresp != 2'b00 && err_q == RECON_ST_OK) ? RECON_ST_RRESP : err_q;
            if (burst_rem_q == 9'd1) state_d = final_beat ? ST_STATUS : ST_ADDR;
         end
         ST_STATUS: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      desc_ready_d = state_d == ST_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         tag_q        <= '0;
         beats_rem_q  <= '0;
         burst_rem_q  <= '0;
         last_keep_q  <= '0;
         err_q        <= RECON_ST_OK;
         desc_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         tag_q        <= tag_d;
         beats_rem_q  <= beats_rem_d;
         burst_rem_q  <= burst_rem_d;
         last_keep_q  <= last_keep_d;
         err_q        <= err_d;
         desc_ready_q <= desc_ready_d;
      end
   end
   recon_axis_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data_i   (bus_if.m_axi_rdata),
      .in_keep_i   (final_beat ? last_keep_q : {BYTES{1'b1}}),
      .in_last_i   (final_beat),
      .in_user_i   (bus_if.m_axi_rresp != 2'b00),
      .in_valid_i  (bus_if.m_axi_rvalid && state_q == ST_DATA),
      .in_ready_o  (skid_ready),
      .out_data_o  (bus_if.m_axis_tdata),
      .out_keep_o  (bus_if.m_axis_tkeep),
      .out_last_o  (bus_if.m_axis_tlast),
      .out_user_o  (bus_if.m_axis_tuser),
      .out_valid_o (bus_if.m_axis_tvalid),
      .out_ready_i (bus_if.m_axis_tready)
   );
`ifdef RECON_BITSTREAM_READER_STATS_EN
   logic [31:0] desc_cnt_q, beat_cnt_q;
   logic [15:0] err_cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         desc_cnt_q <= '0;
         beat_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         if (desc_fire) desc_cnt_q <= desc_cnt_q + 32'd1;
         if (bus_if.m_axis_tvalid && bus_if.m_axis_tready) beat_cnt_q <= beat_cnt_q + 32'd1;
         if (state_q == ST_STATUS && err_q != RECON_ST_OK) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end
   assign stat_desc_count = desc_cnt_q;
   assign stat_beat_count = beat_cnt_q;
   assign stat_err_count  = err_cnt_q;
`endif
endmodule

// File: tb/tb_recon_bitstream_reader.sv
// tb_recon_bitstream_reader: directed bench with a behavioural AXI read memory and stream/status monitors.
module tb_recon_bitstream_reader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0, errors = 0, cyc = 0, stab_err = 0, acc_cyc = 0, st_cyc = 0;
   logic rnd_mode = 1'b0;
   logic [33:0] err_addr = '1;
   logic [73:0] sq[$];
   logic [41:0] arq[$];
   logic [11:0] stq[$];
   logic [20:0] ar_cfg = '0;
   logic stalled = 1'b0;
   logic [73:0] held = '0;
   int r_left = 0;
   logic [33:0] r_addr = '0, a_addr = '0;
   logic [7:0] a_len = '0;
   logic arf, rf;
`ifdef RECON_BITSTREAM_READER_STATS_EN
   logic [31:0] stat_desc_count, stat_beat_count;
   logic [15:0] stat_err_count;
`endif
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   recon_bitstream_reader_if bus ();
   recon_bitstream_reader dut (
      .clk(clk), .rst_n(rst_n), .bus_if(bus)
`ifdef RECON_BITSTREAM_READER_STATS_EN
      , .stat_desc_count(stat_desc_count), .stat_beat_count(stat_beat_count), .stat_err_count(stat_err_count)
`endif
   );
   function automatic logic [63:0] mem_word(input logic [33:0] a);
      return {a[31:0] ^ 32'hDEADBEEF, a[31:0]};
   endfunction
   function automatic logic [41:0] ar_at(input int i);
      return i < arq.size() ? arq[i] : '1;
   endfunction
   // Memory slave: one burst at a time, continuous rvalid, SLVERR at err_addr.
   initial begin
      bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
      bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0; bus.m_axi_rid = '0;
      forever begin
         @(negedge clk);
         arf = bus.m_axi_arvalid && bus.m_axi_arready;
         rf = bus.m_axi_rvalid && bus.m_axi_rready;
         a_addr = bus.m_axi_araddr;
         a_len = bus.m_axi_arlen;
         @(posedge clk); #1;
         if (rf) begin r_left--; r_addr += 34'd8; end
         if (arf) begin r_addr = a_addr; r_left = int'(a_len) + 1; end
         bus.m_axi_rvalid = r_left != 0;
         bus.m_axi_rdata = mem_word(r_addr);
         bus.m_axi_rresp = (r_left != 0 && r_addr == err_addr) ? 2'b10 : 2'b00;
         bus.m_axi_rlast = r_left == 1;
         bus.m_axi_arready = r_left == 0 && rst_n;
      end
   end
   always @(posedge clk) begin
      #1;
      bus.m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end
   always @(negedge clk) begin
      if (bus.m_axis_tvalid && bus.m_axis_tready)
         sq.push_back({bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tuser});
      if (stalled && {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tuser} !== held) stab_err++;
      stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
      held = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tuser};
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
         arq.push_back({bus.m_axi_araddr, bus.m_axi_arlen});
         ar_cfg = {bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock, bus.m_axi_arcache, bus.m_axi_arprot};
      end
      if (bus.m_axis_read_desc_status_valid) begin
         stq.push_back({bus.m_axis_read_desc_status_tag, bus.m_axis_read_desc_status_error});
         st_cyc = cyc;
      end
      if (bus.s_axis_read_desc_valid && bus.s_axis_read_desc_ready) acc_cyc = cyc;
   end
   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask
   task automatic run(input logic [33:0] a, input logic [19:0] l, input logic [7:0] t);
      int n;
      sq.delete(); arq.delete(); stq.delete();
      @(posedge clk); #1;
      bus.s_axis_read_desc_addr = a;
      bus.s_axis_read_desc_len = l;
      bus.s_axis_read_desc_tag = t;
      bus.s_axis_read_desc_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.s_axis_read_desc_ready && n < 100);
      @(posedge clk); #1;
      bus.s_axis_read_desc_valid = 1'b0;
      n = 0;
      while (stq.size() == 0 && n < 3000) begin @(negedge clk); n++; end
      n = 0;
      while (bus.m_axis_tvalid && n < 3000) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
   endtask
   task automatic check_stream(input string name, input logic [33:0] base, input int n, input logic [7:0] lkeep, input int ebeat);
      logic [73:0] e;
      check({name, "_beats"}, sq.size(), n);
      for (int i = 0; i < n && i < sq.size(); i++) begin
         e = {mem_word(base + 34'(8 * i)), (i == n - 1) ? lkeep : 8'hFF, 1'(i == n - 1), 1'(i == ebeat)};
         check($sformatf("%s_beat%0d", name, i), sq[i], e);
      end
   endtask
   task automatic check_status(input string name, input logic [7:0] t, input logic [3:0] e);
      check({name, "_status_count"}, stq.size(), 1);
      check({name, "_status"}, stq.size() > 0 ? stq[0] : 12'hFFF, {t, e});
   endtask
   initial begin
      #800000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      bus.s_axis_read_desc_valid = 1'b0;
      bus.s_axis_read_desc_addr = '0;
      bus.s_axis_read_desc_len = '0;
      bus.s_axis_read_desc_tag = '0;
      repeat (3) @(negedge clk);
      check("rst_desc_ready", bus.s_axis_read_desc_ready, 0);
      check("rst_arvalid", bus.m_axi_arvalid, 0);
      check("rst_rready", bus.m_axi_rready, 0);
      check("rst_tvalid", bus.m_axis_tvalid, 0);
      check("rst_status_valid", bus.m_axis_read_desc_status_valid, 0);
      check("rst_status_fields", {bus.m_axis_read_desc_status_tag, bus.m_axis_read_desc_status_error}, 12'h000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_desc_ready", bus.s_axis_read_desc_ready, 1);
      // 64 bytes at a page start: one 8-beat burst
      run(34'h1000, 20'd64, 8'h11);
      check("t1_ar_count", arq.size(), 1);
      check("t1_ar0", ar_at(0), {34'h1000, 8'd7});
      check("t1_ar_cfg", ar_cfg, {8'h00, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000});
      check_stream("t1", 34'h1000, 8, 8'hFF, -1);
      check_status("t1", 8'h11, 4'd0);
      // 20 bytes: partial final beat
      run(34'h0, 20'd20, 8'h22);
      check("t2_ar_count", arq.size(), 1);
      check("t2_ar0", ar_at(0), {34'h0, 8'd2});
      check_stream("t2", 34'h0, 3, 8'h0F, -1);
      check_status("t2", 8'h22, 4'd0);
      // unaligned start address is forced down to a beat boundary
      run(34'h3005, 20'd8, 8'h27);
      check("t2b_ar0", ar_at(0), {34'h3000, 8'd0});
      check_stream("t2b", 34'h3000, 1, 8'hFF, -1);
      check_status("t2b", 8'h27, 4'd0);
      // 4 KB boundary split
      run(34'hFC0, 20'd256, 8'h33);
      check("t3_ar_count", arq.size(), 3);
      check("t3_ar0", ar_at(0), {34'hFC0, 8'd7});
      check("t3_ar1", ar_at(1), {34'h1000, 8'd15});
      check("t3_ar2", ar_at(2), {34'h1080, 8'd7});
      check_stream("t3", 34'hFC0, 32, 8'hFF, -1);
      check_status("t3", 8'h33, 4'd0);
      // zero length
      run(34'h4000, 20'd0, 8'h44);
      check("t4_ar_count", arq.size(), 0);
      check("t4_beats", sq.size(), 0);
      check_status("t4", 8'h44, 4'd2);
      check("t4_latency", (st_cyc - acc_cyc) <= 2, 1);
      // SLVERR on the third beat
      err_addr = 34'h2010;
      run(34'h2000, 20'd64, 8'h55);
      err_addr = '1;
      check_stream("t5", 34'h2000, 8, 8'hFF, 2);
      check_status("t5", 8'h55, 4'd1);
      // random backpressure
      rnd_mode = 1'b1;
      stab_err = 0;
      run(34'h8000, 20'd1000, 8'h66);
      rnd_mode = 1'b0;
      check("t6_ar_count", arq.size(), 8);
      check("t6_ar_last", ar_at(7), {34'h8380, 8'd12});
      check_stream("t6", 34'h8000, 125, 8'hFF, -1);
      check_status("t6", 8'h66, 4'd0);
      check("t6_stable", stab_err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/recon_bitstream_reader.md
Name: recon_bitstream_reader

Overview:
- Read-side counterpart of the reconfiguration capture path. It takes a DMA read descriptor (address, byte length, tag) and fetches the bitstream from memory over an AXI4 read master.
- It re-emits the data as an AXI-stream, with tkeep/tlast framing, toward the configuration port.
- One descriptor is in flight at a time, and one AXI burst is outstanding at a time. A status word is returned per descriptor.

Parameters:
DATA_WIDTH, 64, AXI/stream data width in bits; power of two, >=8
ADDR_WIDTH, 34, AXI byte address width
ID_WIDTH, 8, AXI ID width
DMA_DESC_LEN_WIDTH, 20, descriptor byte-length width
DMA_DESC_TAG_WIDTH, 8, descriptor tag width
MAX_BURST_LEN, 16, max beats per AR burst (1..256)
AXI_ID, 0, constant arid value

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s_axis_read_desc_addr  in  ADDR_WIDTH  start byte address
s_axis_read_desc_len  in  DMA_DESC_LEN_WIDTH  byte count
s_axis_read_desc_tag  in  DMA_DESC_TAG_WIDTH  tag echoed in status
s_axis_read_desc_valid / _ready  in/out  1  descriptor handshake
m_axis_read_desc_status_tag  out  DMA_DESC_TAG_WIDTH  completed tag
m_axis_read_desc_status_error  out  4  0 ok, 1 rresp error, 2 zero length
m_axis_read_desc_status_valid  out  1  one-cycle pulse
m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  AR channel
m_axi_arvalid out, m_axi_arready in  1  AR handshake
m_axi_rid in ID_WIDTH, m_axi_rdata in DATA_WIDTH, m_axi_rresp in 2, m_axi_rlast in 1, m_axi_rvalid in 1, m_axi_rready out 1  R channel
m_axis_tdata/tkeep  out  DATA_WIDTH/DATA_WIDTH/8  stream data
m_axis_tvalid out, m_axis_tready in, m_axis_tlast out  1  stream handshake
m_axis_tuser  out  1  beat carried non-OKAY rresp

Behaviour:
- Constants: BYTES=DATA_WIDTH/8, OFFS=log2(BYTES).
  - arsize=OFFS, arburst=INCR, arlock=0, arcache=4'b0011, arprot=0, arid=AXI_ID.
- Reset values: all valids 0, s_axis_read_desc_ready 0, m_axi_rready 0, status fields 0, state IDLE.
  - Reset mid-transfer abandons it; no status is emitted.
- FSM IDLE:
  - desc_ready=1. On accept, latch the address with the low OFFS bits forced to 0, latch tag, and set beats_rem=ceil(len/BYTES).
  - Compute last_keep = low (len mod BYTES) bits set, or all ones if the remainder is 0.
  - len==0 -> STATUS with error=2. Otherwise -> ADDR.
- FSM ADDR:
  - Present the burst: beats = min(MAX_BURST_LEN, beats_rem, (4096 - addr[11:0])/BYTES); arlen=beats-1.
  - arvalid is held with stable fields until arready, then -> DATA.
- FSM DATA:
  - m_axi_rready = skid-buffer input ready. Each R handshake passes one beat to the output.
  - tkeep=all ones except the final descriptor beat, which uses last_keep. tlast=1 only on the final descriptor beat.
  - tuser=(rresp!=0). The first non-OKAY rresp sets sticky error=1, and data keeps streaming.
  - Address advances by beats*BYTES per burst; beats_rem is decremented per beat.
  - On rlast: beats_rem==0 -> STATUS, else -> ADDR. rlast arriving early or late relative to the beat count is ignored; the internal count governs.
- FSM STATUS:
  - status_valid pulses for 1 cycle with the tag and error -> IDLE.
  - The next descriptor is accepted no earlier than the cycle after the pulse.
- Stream output goes through a 2-entry skid buffer: registered outputs, full throughput, 1-cycle latency R->tvalid.
  - tready stalls backpressure rready with no data loss. tdata/tkeep/tlast/tuser stay stable while tvalid && !tready.
- Status waits until the last beat enters the skid buffer, not until it drains.

Optional Feature:
- RECON_BITSTREAM_READER_STATS_EN defined: adds outputs stat_desc_count[31:0], stat_beat_count[31:0] and stat_err_count[15:0].
  - These count accepted descriptors, output-stream beats handshaked, and status pulses with error!=0.
  - Counters wrap and are reset to 0.
- Undefined: those ports and counters do not exist.

Decomposition:
- Shared package recon_pkg: status codes (RECON_ST_OK=0, RECON_ST_RRESP=1, RECON_ST_ZERO_LEN=2), AXI constants (INCR burst, cache value), FSM state enum.
- One sub-module, recon_axis_skid_buf (parameterised by DATA_WIDTH, tkeep+tlast+tuser sideband), holds the output register stage.

Test Plan:
- len=64, addr=0x1000, MAX_BURST_LEN=16, tready=1 -> one AR with arlen=7, 8 beats, tkeep=0xFF, tlast on beat 8, status tag echoed, error=0.
- len=20, addr=0x0 -> arlen=2, 3 beats, final tkeep=0x0F with tlast, error=0.
- addr=0xFC0, len=256 -> first burst arlen=7 (stops at the 4KB boundary at 0x1000), then arlen=15 and arlen=7; 32 beats total, single tlast.
- len=0 -> no arvalid; status_valid with error=2 within 2 cycles of the accept.
- Burst with rresp=SLVERR on beat 3 -> tuser=1 on that beat only, all beats still delivered, status error=1.
- Random tready toggling, 50% duty, len=1000 -> data order and values match memory; no beat dropped or duplicated; tdata stable while stalled.
